// File: rtl/dmem_bridge.sv
// dmem_bridge
// -----------------------------------------------------------------------------
// Bridge between the core's single-cycle data-memory port and a word-wide,
// variable-latency req/gnt/rvalid bus. A MemRead/MemWrite request is latched
// in IDLE, turned into one bus transaction, and the core is stalled until the
// one-cycle DONE state, where load data is returned aligned and extended.
//
// Optional feature (compile-time macro DMEM_BRIDGE_TIMEOUT_EN):
//   defined   -> REQ/WAIT are bounded by TIMEOUT_CYCLES; on expiry the access
//                is aborted, BusErr pulses and DONE returns ReadData=0.
//   undefined -> the bridge waits indefinitely and BusErr stays 0.
//
// Ports:
//   CLK, RST                 clock (rising edge), async active-high reset
//   MemRead, MemWrite        core load / store request (both high = store)
//   MemByte, MemHalf         access size (MemByte has priority), else word
//   MemSignExtend            sign- (1) or zero- (0) extend load data
//   ALUOut[31:0]             byte address
//   WriteData[31:0]          right-justified store data
//   ReadData[31:0]           extended load result, valid in DONE only
//   Stall                    freezes the core while a request is in flight
//   AlignErr                 one-cycle pulse (in DONE) for a misaligned access
//   BusErr                   one-cycle pulse (in DONE) for a timeout abort
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata   bus request side
//   mem_gnt/mem_rvalid/mem_rdata               bus response side
// -----------------------------------------------------------------------------
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemByte,
  input  logic        MemHalf,
  input  logic        MemSignExtend,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AlignErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Last counter value before the abort fires; the counter starts at 0 on
  // entry to REQ, so the abort happens in the TIMEOUT_CYCLES-th REQ/WAIT cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic [1:0]  lane_reg;   // address byte offset, selects the load lane(s)
  logic        byte_reg;
  logic        half_reg;   // half access with byte priority already resolved
  logic        sign_reg;

  logic        req_any;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg;
`else
  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = TO_LAST;
`endif

  assign req_any = MemRead | MemWrite;

  // Reset gating keeps Stall low while RST is high even with a request present.
  assign Stall = req_any && (state_reg != DONE) && !RST;

  // Request-side formatting from the live core inputs (used in IDLE only).
  always_comb begin
    is_byte    = MemByte;
    is_half    = !MemByte && MemHalf;
    misaligned = 1'b0;
    be_fmt     = 4'b1111;
    wdata_fmt  = WriteData;
    if (is_byte) begin
      be_fmt    = 4'b0001 << ALUOut[1:0];
      wdata_fmt = {4{WriteData[7:0]}};
    end else if (is_half) begin
      misaligned = ALUOut[0];
      be_fmt     = ALUOut[1] ? 4'b1100 : 4'b0011;
      wdata_fmt  = {2{WriteData[15:0]}};
    end else begin
      misaligned = (ALUOut[1:0] != 2'b00);
    end
  end

  // Load-side lane selection and extension, based on the latched access.
  always_comb begin
    byte_sel = 8'h00;
    case (lane_reg)
      2'd0: byte_sel = mem_rdata[7:0];
      2'd1: byte_sel = mem_rdata[15:8];
      2'd2: byte_sel = mem_rdata[23:16];
      2'd3: byte_sel = mem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (byte_reg) begin
      load_ext = sign_reg ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
    end else if (half_reg) begin
      load_ext = sign_reg ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
    end else begin
      load_ext = mem_rdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      lane_reg  <= 2'b00;
      byte_reg  <= 1'b0;
      half_reg  <= 1'b0;
      sign_reg  <= 1'b0;
      ReadData  <= 32'h0;
      AlignErr  <= 1'b0;
      BusErr    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 30'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          ReadData <= 32'h0;
          AlignErr <= 1'b0;
          BusErr   <= 1'b0;
          if (req_any) begin
            lane_reg  <= ALUOut[1:0];
            byte_reg  <= is_byte;
            half_reg  <= is_half;
            sign_reg  <= MemSignExtend;
            mem_addr  <= ALUOut[31:2];
            mem_wdata <= wdata_fmt;
            if (misaligned) begin
              // No bus access; the error is reported in the DONE cycle.
              AlignErr  <= 1'b1;
              state_reg <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_be    <= be_fmt;
              state_reg <= REQ;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
              cnt_reg   <= '0;
`endif
            end
          end
        end

        REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            state_reg <= mem_we ? DONE : WAIT;
          end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          else if (cnt_reg == TO_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            BusErr    <= 1'b1;
            ReadData  <= 32'h0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end

        WAIT: begin
          if (mem_rvalid) begin
            ReadData  <= load_ext;
            state_reg <= DONE;
          end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          else if (cnt_reg == TO_LAST) begin
            BusErr    <= 1'b1;
            ReadData  <= 32'h0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end

        DONE: begin
          // Core advances at this edge; error pulses and load data end here.
          ReadData  <= 32'h0;
          AlignErr  <= 1'b0;
          BusErr    <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Testbench for dmem_bridge: directed accesses with hand-computed results.
// Stimulus pushes expected bus requests and core responses into queues; a
// monitor pops and compares them whenever the DUT presents a bus grant or a
// DONE cycle. A bus responder model drives gnt/rvalid with per-access delays.
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        MemRead, MemWrite, MemByte, MemHalf, MemSignExtend;
  logic [31:0] ALUOut, WriteData;
  logic [31:0] ReadData;
  logic        Stall, AlignErr, BusErr;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    string       name;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        ae;
    logic        berr;
    int          stall;
    string       name;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  // Responder configuration, written only by the stimulus process.
  int          gnt_wait  = 0;
  int          rv_delay  = 1;
  logic [31:0] rdata_val = 32'h0;
  int          txn_id    = 0;

  dmem_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemByte(MemByte), .MemHalf(MemHalf),
    .MemSignExtend(MemSignExtend), .ALUOut(ALUOut), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AlignErr(AlignErr), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Bus responder: gnt after gnt_wait REQ cycles, rvalid rv_delay cycles after gnt.
  initial begin
    int wait_cnt  = 0;
    int rv_cnt    = 0;
    int served_id = 0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rst) begin
        wait_cnt  = 0;
        rv_cnt    = 0;
        served_id = txn_id;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata_val;
        end
      end else if (mem_req && served_id != txn_id) begin
        if (wait_cnt == gnt_wait) begin
          mem_gnt   = 1'b1;
          served_id = txn_id;
          wait_cnt  = 0;
          if (!mem_we) rv_cnt = rv_delay;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    int   stall_cnt = 0;
    logic req_prev  = 1'b0;
    logic gnt_prev  = 1'b0;
    bus_exp_t  be_e;
    resp_exp_t rs_e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
        req_prev  = 1'b0;
        gnt_prev  = 1'b0;
      end else begin
        if (Stall) stall_cnt++;

        if (mem_req) begin
          chk("req_expected", 32'(bus_q.size() > 0), 32'd1);
          if (bus_q.size() > 0) begin
            be_e = bus_q[0];
            chk({be_e.name, ".addr"}, 32'(mem_addr), 32'(be_e.addr));
            chk({be_e.name, ".be"},   32'(mem_be),   32'(be_e.be));
            chk({be_e.name, ".we"},   32'(mem_we),   32'(be_e.we));
            if (be_e.we) chk({be_e.name, ".wdata"}, mem_wdata, be_e.wdata);
            if (mem_gnt) void'(bus_q.pop_front());
          end
        end else begin
          // Request withdrawn without a grant (timeout abort).
          if (req_prev && !gnt_prev && bus_q.size() > 0) void'(bus_q.pop_front());
          chk("idle_be_we", {27'h0, mem_be, mem_we}, 32'h0);
        end
        req_prev = mem_req;
        gnt_prev = mem_gnt;

        if ((MemRead || MemWrite) && !Stall) begin
          chk("done_expected", 32'(resp_q.size() > 0), 32'd1);
          if (resp_q.size() > 0) begin
            rs_e = resp_q.pop_front();
            chk({rs_e.name, ".ReadData"}, ReadData, rs_e.rd);
            chk({rs_e.name, ".AlignErr"}, 32'(AlignErr), 32'(rs_e.ae));
            chk({rs_e.name, ".BusErr"},   32'(BusErr),   32'(rs_e.berr));
            chk({rs_e.name, ".stall_cycles"}, 32'(stall_cnt), 32'(rs_e.stall));
            chk({rs_e.name, ".req_in_done"}, 32'(mem_req), 32'd0);
            $display("txn %s rd=%h ae=%0d be=%0d stall=%0d", rs_e.name, ReadData,
                     AlignErr, BusErr, stall_cnt);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic clear_inputs();
    MemRead = 0; MemWrite = 0; MemByte = 0; MemHalf = 0; MemSignExtend = 0;
    ALUOut = 32'h0; WriteData = 32'h0;
  endtask

  task automatic access(input string name, input bit rd, input bit wr, input bit by,
                        input bit hf, input bit sx, input logic [31:0] addr,
                        input logic [31:0] wd, input int gw, input int rvd,
                        input logic [31:0] rdat, input bit exp_bus,
                        input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic [31:0] erd, input bit eae, input bit eberr,
                        input int estall);
    bit done = 0;
    if (exp_bus) bus_q.push_back('{wr, addr[31:2], ebe, ewd, name});
    resp_q.push_back('{erd, eae, eberr, estall, name});
    gnt_wait  = gw;
    rv_delay  = rvd;
    rdata_val = rdat;
    txn_id++;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; MemByte = by; MemHalf = hf; MemSignExtend = sx;
    ALUOut = addr; WriteData = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!Stall) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s.done_timeout actual=stalled required=DONE", name);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    MemRead = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset.Stall",    32'(Stall),    32'd0);
    chk("reset.mem_req",  32'(mem_req),  32'd0);
    chk("reset.ReadData", ReadData,      32'h0);
    chk("reset.errs",     {30'h0, AlignErr, BusErr}, 32'h0);
    chk("reset.be_we",    {27'h0, mem_be, mem_we}, 32'h0);
    MemRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    //      name          rd wr by hf sx addr          wdata         gw rv rdata        bus be       ewdata        erd          ae be st
    access("wr_word",      0, 1, 0, 0, 0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        1, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 0, 2);
    access("ld_sbyte",     1, 0, 1, 0, 1, 32'h203, 32'h0,        0, 2, 32'h80123456, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0, 4);
    access("st_half_gw3",  0, 1, 0, 1, 0, 32'h002, 32'h0000ABCD, 3, 0, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0, 5);
    access("ld_word_mis",  1, 0, 0, 0, 0, 32'h101, 32'h0,        0, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 0, 1);
    access("ld_ubyte",     1, 0, 1, 0, 0, 32'h201, 32'h0,        0, 1, 32'h12348056, 1, 4'b0010, 32'h0,        32'h00000080, 0, 0, 3);
    access("ld_shalf",     1, 0, 0, 1, 1, 32'h000, 32'h0,        0, 1, 32'h1234F00D, 1, 4'b0011, 32'h0,        32'hFFFFF00D, 0, 0, 3);
    access("st_byte",      0, 1, 1, 0, 0, 32'h003, 32'h000000A5, 0, 0, 32'h0,        1, 4'b1000, 32'hA5A5A5A5, 32'h0,        0, 0, 2);
    access("rd_wr_both",   1, 1, 0, 0, 0, 32'h010, 32'h01020304, 0, 0, 32'h0,        1, 4'b1111, 32'h01020304, 32'h0,        0, 0, 2);
    access("st_half_mis",  0, 1, 0, 1, 0, 32'h005, 32'h00001234, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 0, 1);
    access("ld_word",      1, 0, 0, 0, 1, 32'h008, 32'h0,        0, 1, 32'hCAFEF00D, 1, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 0, 3);

    // Reset while waiting for read data.
    bus_q.push_back('{1'b0, 30'h4, 4'b1111, 32'h0, "rst_wait"});
    gnt_wait = 0;
    rv_delay = 10;
    txn_id++;
    @(posedge clk); #1;
    MemRead = 1'b1; ALUOut = 32'h10;
    @(posedge clk);          // enter REQ, grant follows in this cycle
    @(posedge clk); #2;      // now in WAIT
    chk("rst_wait.Stall_before", 32'(Stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wait.mem_req",  32'(mem_req), 32'd0);
    chk("rst_wait.Stall",    32'(Stall),   32'd0);
    chk("rst_wait.ReadData", ReadData,     32'h0);
    $display("txn rst_wait req=%0d stall=%0d rd=%h", mem_req, Stall, ReadData);
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    access("ld_uhalf_post", 1, 0, 0, 1, 0, 32'h006, 32'h0, 0, 1, 32'hFFFF1234, 1, 4'b1100, 32'h0, 32'h0000FFFF, 0, 0, 3);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    access("timeout", 1, 0, 0, 0, 0, 32'h020, 32'h0, 1000, 0, 32'h0, 1, 4'b1111, 32'h0, 32'h0, 0, 1, 5);
    @(negedge clk);
    chk("timeout.after_BusErr",  32'(BusErr),  32'd0);
    chk("timeout.after_mem_req", 32'(mem_req), 32'd0);
    chk("timeout.after_Stall",   32'(Stall),   32'd0);
`endif

    for (int i = 0; i < 50 && (bus_q.size() != 0 || resp_q.size() != 0); i++) @(negedge clk);
    chk("queues_drained", 32'(bus_q.size() + resp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Downstream neighbour of the processor core's data-memory port; sits between the core and a word-wide, variable-latency data-memory bus.
- Converts the core's single-cycle MemRead/MemWrite request into a req/gnt/rvalid bus transaction.
- Generates byte enables for byte, half and word accesses, aligns and extends load data, and stalls the core until the access completes.

Parameters:
- TIMEOUT_CYCLES, 64, bus cycles allowed in REQ+WAIT before the access is aborted (used only with the optional feature).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- MemRead  in  1  core load request.
- MemWrite  in  1  core store request.
- MemByte  in  1  byte access.
- MemHalf  in  1  halfword access; MemByte has priority.
- MemSignExtend  in  1  sign-extend load data (1) or zero-extend it (0).
- ALUOut  in  32  byte address.
- WriteData  in  32  store data, right-justified.
- ReadData  out  32  extended load result; valid only in DONE.
- Stall  out  1  freezes core PC and pipeline.
- AlignErr  out  1  one-cycle pulse on a misaligned access.
- BusErr  out  1  one-cycle pulse on a timeout abort.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  30  word address, ALUOut[31:2].
- mem_be  out  4  byte enables, bit k = byte lane k.
- mem_wdata  out  32  bus write data.
- mem_gnt  in  1  bus accepts the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset: async to IDLE; every output and internal register (including mem_req) reads 0 while RST is high. Asserting RST mid-transaction abandons the access; mem_req drops immediately and no gnt/rvalid is expected afterwards.
- Stall is combinational: (MemRead|MemWrite) && state!=DONE. It is 0 whenever no request is present.
- IDLE, request present: latch address, size, sign, we and formatted data. Aligned -> REQ. Misaligned -> DONE with AlignErr=1 that cycle, no bus access, ReadData=0.
- MemRead and MemWrite both high: treated as a write.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
- REQ: mem_req=1; all bus outputs held stable until mem_gnt. On gnt, write -> DONE, read -> WAIT. mem_req falls the cycle after gnt.
- WAIT: on mem_rvalid, capture mem_rdata -> DONE. The bus never returns rvalid in the gnt cycle.
- DONE: lasts one cycle, Stall=0, ReadData valid; next state IDLE. The core advances at the following edge.
- Latency from request cycle to DONE: write 2 cycles when gnt is immediate; read 3 cycles when rvalid arrives one cycle after gnt.
- Byte access: be = 1<<addr[1:0]; wdata = WriteData[7:0] replicated into all four lanes.
- Half access: be = addr[1] ? 1100 : 0011; wdata = {2{WriteData[15:0]}}.
- Word access: be = 1111; wdata = WriteData.
- Loads: select the lane(s) by addr and extend per MemSignExtend. Example: byte 0x80 -> 0xFFFFFF80 signed, 0x00000080 unsigned.
- mem_be and mem_we are meaningful only while mem_req=1; both are 0 otherwise.

Optional Feature:
- Macro: DMEM_BRIDGE_TIMEOUT_EN.
- Defined: a counter clears on entry to REQ and increments every cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES with no gnt/rvalid: drop mem_req, pulse BusErr, go to DONE with ReadData=0. A late rvalid arriving in IDLE is ignored.
- Not defined: no counter; the bridge waits indefinitely and BusErr is tied to 0.

Test Plan:
- Aligned word write, addr 0x100, data 0xDEADBEEF, gnt immediate -> mem_addr=0x40, be=1111, Stall high 2 cycles, DONE, mem_req low afterwards.
- Signed byte load, addr 0x203, rdata 0x80123456 delivered 2 cycles after gnt -> ReadData=0xFFFFFF80, Stall released exactly in the DONE cycle.
- Half store, addr 0x2, data 0x0000ABCD, gnt delayed 3 cycles -> be=1100, wdata=0xABCDABCD held stable through all REQ cycles.
- Misaligned word load, addr 0x101 -> AlignErr pulses 1 cycle, mem_req never asserted, ReadData=0, Stall high 1 cycle.
- RST asserted in WAIT -> mem_req, Stall and ReadData are 0 asynchronously; after release, a new unsigned half load of 0xFFFF returns 0x0000FFFF.
- With DMEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never asserted -> BusErr pulses after 4 REQ cycles, then DONE, then IDLE.
